// File: rtl/aes_shift_rows_pipe.sv
// Pipelined ShiftRows / InvShiftRows stage for Nb = 4, 6 or 8 columns.
// Per-beat direction and tag; output register plus skid buffer for full rate under backpressure.
module aes_shift_rows_pipe #(
  parameter int NB    = 4,
  parameter int TAG_W = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [0:32*NB-1]    in_data,
  input  logic                in_inv,
  input  logic [TAG_W-1:0]    in_tag,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [0:32*NB-1]    out_data,
  output logic [TAG_W-1:0]    out_tag
);

  localparam int W = 32 * NB;

  if (!(NB == 4 || NB == 6 || NB == 8)) begin : g_bad_nb
    $error("aes_shift_rows_pipe: NB must be 4, 6 or 8");
  end
  if (TAG_W < 1) begin : g_bad_tag
    $error("aes_shift_rows_pipe: TAG_W must be at least 1");
  end

  // Rijndael row offsets: 256-bit blocks shift rows 2 and 3 one extra column.
  function automatic int shift_of(input int r);
    if (NB == 8 && r >= 2) return r + 1;
    return r;
  endfunction

  logic [0:W-1] perm_data;

  for (genvar r = 0; r < 4; r++) begin : g_row
    for (genvar c = 0; c < NB; c++) begin : g_col
      localparam int S  = shift_of(r);
      localparam int K  = 4 * c + r;
      localparam int KF = 4 * ((c + S) % NB) + r;
      localparam int KI = 4 * ((c - S + NB) % NB) + r;
      assign perm_data[8*K +: 8] = in_inv ? in_data[8*KI +: 8] : in_data[8*KF +: 8];
    end
  end

  logic             or_valid_q, or_valid_d;
  logic [0:W-1]     or_data_q,  or_data_d;
  logic [TAG_W-1:0] or_tag_q,   or_tag_d;
  logic             sk_valid_q, sk_valid_d;
  logic [0:W-1]     sk_data_q,  sk_data_d;
  logic [TAG_W-1:0] sk_tag_q,   sk_tag_d;
  logic             in_fire, out_fire;

  assign in_ready  = ~sk_valid_q;
  assign out_valid = or_valid_q;
  assign out_data  = or_data_q;
  assign out_tag   = or_tag_q;

  assign in_fire  = in_valid & ~sk_valid_q;
  assign out_fire = or_valid_q & out_ready;

  always_comb begin
    or_valid_d = or_valid_q;
    or_data_d  = or_data_q;
    or_tag_d   = or_tag_q;
    sk_valid_d = sk_valid_q;
    sk_data_d  = sk_data_q;
    sk_tag_d   = sk_tag_q;
    if (!or_valid_q || out_fire) begin
      if (sk_valid_q) begin
        or_valid_d = 1'b1;
        or_data_d  = sk_data_q;
        or_tag_d   = sk_tag_q;
        sk_valid_d = 1'b0;
      end else if (in_fire) begin
        or_valid_d = 1'b1;
        or_data_d  = perm_data;
        or_tag_d   = in_tag;
      end else begin
        or_valid_d = 1'b0;
      end
    end else if (in_fire) begin
      // in_fire implies SK is empty, so nothing is overwritten here.
      sk_valid_d = 1'b1;
      sk_data_d  = perm_data;
      sk_tag_d   = in_tag;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      or_valid_q <= 1'b0;
      or_data_q  <= '0;
      or_tag_q   <= '0;
      sk_valid_q <= 1'b0;
      sk_data_q  <= '0;
      sk_tag_q   <= '0;
    end else begin
      or_valid_q <= or_valid_d;
      or_data_q  <= or_data_d;
      or_tag_q   <= or_tag_d;
      sk_valid_q <= sk_valid_d;
      sk_data_q  <= sk_data_d;
      sk_tag_q   <= sk_tag_d;
    end
  end

endmodule

// File: tb/tb_aes_shift_rows_pipe.sv
// Bench for aes_shift_rows_pipe: NB=4, 6 and 8 instances share one handshake and stimulus,
// a negedge monitor scoreboards every beat against a byte-level reference model.
module tb_aes_shift_rows_pipe;

  logic clk, rst_n;
  logic in_valid, in_inv, out_ready;
  logic [3:0] in_tag;
  logic [0:255] din;
  logic ir4, ir6, ir8, ov4, ov6, ov8;
  logic [0:127] dout4;
  logic [0:191] dout6;
  logic [0:255] dout8;
  logic [3:0] tag4, tag6, tag8;

  int checks = 0;
  int errors = 0;

  aes_shift_rows_pipe #(.NB(4), .TAG_W(4)) u_nb4 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(ir4), .in_data(din[0:127]),
    .in_inv(in_inv), .in_tag(in_tag), .out_valid(ov4), .out_ready(out_ready),
    .out_data(dout4), .out_tag(tag4));
  aes_shift_rows_pipe #(.NB(6), .TAG_W(4)) u_nb6 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(ir6), .in_data(din[0:191]),
    .in_inv(in_inv), .in_tag(in_tag), .out_valid(ov6), .out_ready(out_ready),
    .out_data(dout6), .out_tag(tag6));
  aes_shift_rows_pipe #(.NB(8), .TAG_W(4)) u_nb8 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(ir8), .in_data(din),
    .in_inv(in_inv), .in_tag(in_tag), .out_valid(ov8), .out_ready(out_ready),
    .out_data(dout8), .out_tag(tag8));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Forward gathers from column c+s; inverse scatters column c to c+s.
  function automatic logic [0:255] model(input int nb, input logic [0:255] d, input logic inv);
    logic [0:255] o;
    int s;
    o = '0;
    for (int r = 0; r < 4; r++) begin
      s = (nb == 8 && r >= 2) ? r + 1 : r;
      for (int c = 0; c < nb; c++) begin
        if (!inv) o[8*(4*c+r) +: 8] = d[8*(4*((c+s)%nb)+r) +: 8];
        else      o[8*(4*((c+s)%nb)+r) +: 8] = d[8*(4*c+r) +: 8];
      end
    end
    return o;
  endfunction

  function automatic logic [0:255] rand256();
    logic [0:255] v;
    for (int i = 0; i < 8; i++) v[32*i +: 32] = $urandom;
    return v;
  endfunction

  typedef struct {
    logic [0:255] d4;
    logic [0:255] d6;
    logic [0:255] d8;
    logic [3:0]   tag;
  } exp_t;

  exp_t sb[$];
  exp_t e;
  logic [0:255] e4, e6, e8;
  logic stall_q = 1'b0;
  logic [0:127] s4;
  logic [0:191] s6;
  logic [0:255] s8;
  logic [3:0] st4;

  always @(negedge clk) begin
    if (!rst_n) begin
      sb.delete();
      stall_q = 1'b0;
    end else begin
      if (stall_q) begin
        checks++;
        if (!(ov4 && ov6 && ov8) || dout4 !== s4 || dout6 !== s6 || dout8 !== s8 || tag4 !== st4) begin
          errors++;
          $display("FAIL stall_hold: got v=%b%b%b d4=%h tag=%h, held d4=%h tag=%h", ov4, ov6, ov8, dout4, tag4, s4, st4);
        end
      end
      stall_q = ov4 && !out_ready;
      s4 = dout4; s6 = dout6; s8 = dout8; st4 = tag4;
      if (ov4 && out_ready) begin
        checks++;
        if (sb.size() == 0) begin
          errors++;
          $display("FAIL sb_underflow: out_valid with d4=%h tag=%h, expected no beat", dout4, tag4);
        end else begin
          e = sb.pop_front();
          e4 = e.d4; e6 = e.d6; e8 = e.d8;
          if (!(ov6 && ov8) || dout4 !== e4[0:127] || dout6 !== e6[0:191] || dout8 !== e8 ||
              tag4 !== e.tag || tag6 !== e.tag || tag8 !== e.tag) begin
            errors++;
            $display("FAIL sb_data: got d4=%h d6=%h d8=%h tags=%h/%h/%h, exp d4=%h d6=%h d8=%h tag=%h",
                     dout4, dout6, dout8, tag4, tag6, tag8, e4[0:127], e6[0:191], e8, e.tag);
          end
        end
      end
      if (ir4 !== ir6 || ir4 !== ir8 || ov4 !== ov6 || ov4 !== ov8) begin
        checks++; errors++;
        $display("FAIL lockstep: in_ready=%b%b%b out_valid=%b%b%b, exp all equal", ir4, ir6, ir8, ov4, ov6, ov8);
      end
      if (in_valid && ir4) begin
        e.d4 = model(4, din, in_inv);
        e.d6 = model(6, din, in_inv);
        e.d8 = model(8, din, in_inv);
        e.tag = in_tag;
        sb.push_back(e);
      end
    end
  end

  task automatic test_reset();
    rst_n = 1'b0; in_valid = 1'b0; in_inv = 1'b0; in_tag = '0; din = '0; out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (ov4 !== 1'b0 || ov6 !== 1'b0 || ov8 !== 1'b0 || ir4 !== 1'b1 || ir8 !== 1'b1) begin
      errors++; $display("FAIL reset_flags: out_valid=%b%b%b in_ready=%b, exp 000 and 1", ov4, ov6, ov8, ir4);
    end
    checks++;
    if (dout4 !== '0 || dout6 !== '0 || dout8 !== '0 || tag4 !== 4'h0 || tag8 !== 4'h0) begin
      errors++; $display("FAIL reset_data: d8=%h tag=%h, exp zero", dout8, tag4);
    end
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_known_vectors();
    out_ready = 1'b1;
    in_valid = 1'b1; in_inv = 1'b0; in_tag = 4'd3;
    din = {128'hd42711aee0bf98f1b8b45de51e415230, 128'h0};
    @(posedge clk); #1;
    checks++;
    if (ov4 !== 1'b1 || dout4 !== 128'hd4bf5d30e0b452aeb84111f11e2798e5 || tag4 !== 4'd3) begin
      errors++; $display("FAIL fwd_nb4: v=%b d=%h tag=%h, exp 1 d4bf5d30e0b452aeb84111f11e2798e5 3", ov4, dout4, tag4);
    end
    in_inv = 1'b1; in_tag = 4'd5;
    din = {128'hd4bf5d30e0b452aeb84111f11e2798e5, 128'h0};
    @(posedge clk); #1;
    checks++;
    if (ov4 !== 1'b1 || dout4 !== 128'hd42711aee0bf98f1b8b45de51e415230 || tag4 !== 4'd5) begin
      errors++; $display("FAIL inv_nb4: v=%b d=%h tag=%h, exp 1 d42711aee0bf98f1b8b45de51e415230 5", ov4, dout4, tag4);
    end
    in_inv = 1'b0; in_tag = 4'd7;
    din = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
    @(posedge clk); #1;
    checks++;
    if (ov8 !== 1'b1 || dout8[0:31] !== 32'h00050e13 || tag8 !== 4'd7) begin
      errors++; $display("FAIL fwd_nb8: v=%b bytes0-3=%h tag=%h, exp 1 00050e13 7", ov8, dout8[0:31], tag8);
    end
    in_valid = 1'b0;
    @(posedge clk); #1;
    checks++;
    if (ov4 !== 1'b0) begin
      errors++; $display("FAIL known_drain: out_valid=%b, exp 0", ov4);
    end
  endtask

  // Each pair feeds the stage's own forward result back in with inv=1.
  task automatic test_back_to_back();
    logic [0:127] x;
    int bad = 0;
    out_ready = 1'b1;
    for (int i = 0; i < 16; i++) begin
      x = {$urandom, $urandom, $urandom, $urandom};
      in_valid = 1'b1; in_inv = 1'b0; in_tag = 4'(i); din = {x, 128'h0};
      @(posedge clk); #1;
      in_inv = 1'b1; in_tag = 4'(i + 1); din = {dout4, 128'h0};
      @(posedge clk); #1;
      if (ov4 !== 1'b1 || dout4 !== x) bad++;
    end
    in_valid = 1'b0;
    @(posedge clk); #1;
    checks++;
    if (bad != 0) begin
      errors++; $display("FAIL round_trip: %0d of 16 pairs differed, exp 0", bad);
    end
  endtask

  task automatic test_backpressure();
    logic [0:255] beat [3];
    logic ir [8];
    int acc = 0;
    logic ov_end;
    for (int i = 0; i < 3; i++) beat[i] = rand256();
    for (int cyc = 0; cyc < 8; cyc++) begin
      out_ready = (cyc >= 5);
      in_valid = (acc < 3);
      in_inv = cyc[0]; in_tag = 4'(8 + acc);
      din = beat[acc < 3 ? acc : 2];
      @(negedge clk);
      ir[cyc] = ir4;
      if (in_valid && ir4) acc++;
      if (cyc == 4) begin
        checks++;
        if (acc != 2 || ir[2] !== 1'b0 || ir[4] !== 1'b0) begin
          errors++; $display("FAIL bp_stall: accepted=%0d in_ready[2]=%b in_ready[4]=%b, exp 2 0 0", acc, ir[2], ir[4]);
        end
      end
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    ov_end = ov4;
    checks++;
    if (acc != 3 || ir[0] !== 1'b1 || ir[1] !== 1'b1 || ir[6] !== 1'b1 || ov_end !== 1'b0) begin
      errors++; $display("FAIL bp_release: accepted=%0d in_ready0/1/6=%b%b%b out_valid=%b, exp 3 111 0",
                         acc, ir[0], ir[1], ir[6], ov_end);
    end
  endtask

  task automatic test_random();
    int acc = 0;
    int cyc = 0;
    while (acc < 10000 && cyc < 60000) begin
      out_ready = $urandom_range(0, 1);
      in_valid = $urandom_range(0, 1);
      in_inv = $urandom_range(0, 1);
      in_tag = 4'($urandom);
      din = rand256();
      @(negedge clk);
      if (in_valid && ir4) acc++;
      @(posedge clk); #1;
      cyc++;
    end
    checks++;
    if (acc != 10000) begin
      errors++; $display("FAIL random_budget: accepted=%0d in %0d cycles, exp 10000", acc, cyc);
    end
    in_valid = 1'b0; out_ready = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    checks++;
    if (sb.size() != 0 || ov4 !== 1'b0) begin
      errors++; $display("FAIL random_drain: pending=%0d out_valid=%b, exp 0 0", sb.size(), ov4);
    end
  endtask

  task automatic test_reset_mid_stream();
    logic [0:255] r3, m;
    out_ready = 1'b0; in_valid = 1'b1; in_inv = 1'b0; in_tag = 4'd1; din = rand256();
    @(posedge clk); #1;
    in_tag = 4'd2; din = rand256();
    @(posedge clk); #1;
    in_valid = 1'b0;
    checks++;
    if (ir4 !== 1'b0 || ov4 !== 1'b1) begin
      errors++; $display("FAIL mid_fill: in_ready=%b out_valid=%b, exp 0 1", ir4, ov4);
    end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (ov4 !== 1'b0 || ov8 !== 1'b0 || ir4 !== 1'b1 || ir6 !== 1'b1 || dout6 !== '0 || tag6 !== 4'h0) begin
      errors++; $display("FAIL async_reset: out_valid=%b in_ready=%b d6=%h tag=%h, exp 0 1 0 0", ov4, ir4, dout6, tag6);
    end
    @(posedge clk);
    @(posedge clk); #1;
    r3 = rand256();
    in_valid = 1'b1; in_inv = 1'b1; in_tag = 4'd9; din = r3; out_ready = 1'b1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    m = model(6, r3, 1'b1);
    checks++;
    if (ov6 !== 1'b1 || dout6 !== m[0:191] || tag6 !== 4'd9) begin
      errors++; $display("FAIL post_reset_beat: v=%b d6=%h tag=%h, exp 1 %h 9", ov6, dout6, tag6, m[0:191]);
    end
    @(posedge clk); #1;
    checks++;
    if (ov4 !== 1'b0 || ir4 !== 1'b1) begin
      errors++; $display("FAIL no_stale_beat: out_valid=%b in_ready=%b, exp 0 1", ov4, ir4);
    end
  endtask

  initial begin
    test_reset();
    test_known_vectors();
    test_back_to_back();
    test_backpressure();
    test_random();
    test_reset_mid_stream();
    repeat (2) @(posedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
